// File: rtl/instruction_pkg.sv
// Instruction-stream constants shared by the fetch path.
package instruction_pkg;

    localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/typedef_pkg.sv
// Shared fetch types: FSM state encoding and the packet stored in the fetch queue.
package typedef_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    // Packet fields are 32 bits wide, so ADDR_WIDTH and DATA_WIDTH must not exceed 32.
    typedef struct packed {
        logic [31:0] instruction_addr;
        logic [31:0] instruction;
    } fetch_packet_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two circular buffer with push, pop, flush and an occupancy count.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage is not reset; only the pointers and count are, so nothing stale is ever visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory request FSM feeding a decode queue.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch
    import typedef_pkg::*;
    import instruction_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            imem_req_valid,
    input  logic                            imem_req_ready,
    output logic [ADDR_WIDTH-1:0]           imem_req_addr,
    input  logic                            imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]           imem_rsp_data,
    input  logic                            redirect_valid,
    input  logic [ADDR_WIDTH-1:0]           redirect_pc,
    output logic                            dec_valid,
    input  logic                            dec_ready,
    output logic [ADDR_WIDTH-1:0]           dec_instruction_addr,
    output logic [DATA_WIDTH-1:0]           dec_instruction,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_fetched,
    output logic [31:0]                     perf_flushes
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    fetch_state_e          state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [ADDR_WIDTH-1:0] req_pc, req_pc_next;
    logic                  push, pop, flush, req_fire;
    fetch_packet_t         push_pkt, head_pkt;
    logic [CNT_W-1:0]      count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= req_pc_next;
        end
    end

    // Request is held off during reset and redirect cycles, so the address is stable while pending.
    assign imem_req_valid = (state == S_REQ) && (count < CNT_W'(FIFO_DEPTH)) && !redirect_valid && !rst;
    assign imem_req_addr  = imem_req_valid ? pc : '0;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        push        = 1'b0;
        flush       = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_next = redirect_pc & ~ADDR_WIDTH'(3);
            case (state)
                S_WAIT, S_DROP: state_next = imem_rsp_valid ? S_REQ : S_DROP;
                default:        state_next = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc_next = pc;
                        pc_next     = pc + ADDR_WIDTH'(PC_INCREMENT);
                        state_next  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        push       = 1'b1;
                        state_next = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) state_next = S_REQ;
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    assign push_pkt.instruction_addr = 32'(req_pc);
    assign push_pkt.instruction      = 32'(imem_rsp_data);

    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready && !redirect_valid;

    fetch_fifo #(
        .WIDTH ($bits(fetch_packet_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_pkt),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_pkt),
        .count     (count)
    );

    assign fifo_count           = count;
    assign dec_instruction_addr = dec_valid ? ADDR_WIDTH'(head_pkt.instruction_addr) : '0;
    assign dec_instruction      = dec_valid ? DATA_WIDTH'(head_pkt.instruction) : '0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (push)           perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with hand-computed expectations.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instruction_addr;
    logic [31:0] dec_instruction;
    logic [2:0]  fifo_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk                  (clk),
        .rst                  (rst),
        .imem_req_valid       (imem_req_valid),
        .imem_req_ready       (imem_req_ready),
        .imem_req_addr        (imem_req_addr),
        .imem_rsp_valid       (imem_rsp_valid),
        .imem_rsp_data        (imem_rsp_data),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .dec_valid            (dec_valid),
        .dec_ready            (dec_ready),
        .dec_instruction_addr (dec_instruction_addr),
        .dec_instruction      (dec_instruction),
        .fifo_count           (fifo_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched         (perf_fetched),
        .perf_flushes         (perf_flushes)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed and outputs sampled at +1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        tick();
        tick();
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'(0));
        check("rst_req_addr", 64'(imem_req_addr), 64'(0));
        check("rst_dec_valid", 64'(dec_valid), 64'(0));
        check("rst_count", 64'(fifo_count), 64'(0));
        check("rst_dec_addr", 64'(dec_instruction_addr), 64'(0));
        check("rst_dec_inst", 64'(dec_instruction), 64'(0));

        // Streaming: request 0x0, response, pop, request 0x4, response.
        tick(); rst = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1; #1;
        check("c0_req_valid", 64'(imem_req_valid), 64'(1));
        check("c0_req_addr", 64'(imem_req_addr), 64'(32'h0));
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = word(0); #1;
        check("wait_req_valid", 64'(imem_req_valid), 64'(0));
        tick(); imem_rsp_valid = 1'b0; #1;
        check("w0_dec_valid", 64'(dec_valid), 64'(1));
        check("w0_dec_addr", 64'(dec_instruction_addr), 64'(32'h0));
        check("w0_dec_inst", 64'(dec_instruction), 64'(word(0)));
        check("w0_count", 64'(fifo_count), 64'(1));
        check("req_addr_4", 64'(imem_req_addr), 64'(32'h4));
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = word(1); #1;
        check("popped_count", 64'(fifo_count), 64'(0));
        tick(); imem_rsp_valid = 1'b0; #1;
        check("w1_dec_addr", 64'(dec_instruction_addr), 64'(32'h4));
        check("w1_dec_inst", 64'(dec_instruction), 64'(word(1)));
        check("req_addr_8", 64'(imem_req_addr), 64'(32'h8));

        // Back-pressure: decode stalls, queue fills to 4 with words 2..5 at 0x8..0x14.
        tick(); dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = word(2 + i); #1;
            tick(); imem_rsp_valid = 1'b0; #1;
            check("fill_count", 64'(fifo_count), 64'(i + 1));
            if (i < 3) tick();
        end
        check("full_req_valid", 64'(imem_req_valid), 64'(0));
        check("full_head_addr", 64'(dec_instruction_addr), 64'(32'h8));
        check("full_head_inst", 64'(dec_instruction), 64'(word(2)));
        tick(); dec_ready = 1'b1; #1;
        check("full_pop_count", 64'(fifo_count), 64'(4));
        tick(); dec_ready = 1'b0; #1;
        check("after_pop_count", 64'(fifo_count), 64'(3));
        check("after_pop_valid", 64'(imem_req_valid), 64'(1));
        check("after_pop_addr", 64'(imem_req_addr), 64'(32'h18));
        check("after_pop_head", 64'(dec_instruction_addr), 64'(32'hC));

        // Redirect while waiting; stale response two cycles later is dropped.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
        check("redir_req_valid", 64'(imem_req_valid), 64'(0));
        tick(); redirect_valid = 1'b0; #1;
        check("redir_count", 64'(fifo_count), 64'(0));
        check("drop_req_valid", 64'(imem_req_valid), 64'(0));
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; #1;
        tick(); imem_rsp_valid = 1'b0; #1;
        check("stale_count", 64'(fifo_count), 64'(0));
        check("stale_dec_valid", 64'(dec_valid), 64'(0));
        check("redir_req_addr", 64'(imem_req_addr), 64'(32'h100));

        // Redirect coincident with a response and a decode handshake.
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = word(6); #1;
        tick(); imem_rsp_valid = 1'b0; #1;
        check("w6_count", 64'(fifo_count), 64'(1));
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = word(7); dec_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        check("coinc_dec_valid", 64'(dec_valid), 64'(1));
        tick(); imem_rsp_valid = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b0; #1;
        check("coinc_count", 64'(fifo_count), 64'(0));
        check("coinc_req_valid", 64'(imem_req_valid), 64'(1));
        check("coinc_req_addr", 64'(imem_req_addr), 64'(32'h200));
        tick(); #1;
        check("stall_req_valid", 64'(imem_req_valid), 64'(1));
        check("stall_req_addr", 64'(imem_req_addr), 64'(32'h200));

        // Address wrap from 0xFFFF_FFFC.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
        tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1; #1;
        check("wrap_req_addr", 64'(imem_req_addr), 64'(32'hFFFF_FFFC));
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = word(8); imem_req_ready = 1'b0; #1;
        tick(); imem_rsp_valid = 1'b0; #1;
        check("wrap_dec_addr", 64'(dec_instruction_addr), 64'(32'hFFFF_FFFC));
        check("wrap_next_addr", 64'(imem_req_addr), 64'(32'h0));

        // Back-to-back redirects: the last one wins and the queue is flushed.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
        tick(); redirect_pc = 32'h404; #1;
        tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1; #1;
        check("b2b_req_addr", 64'(imem_req_addr), 64'(32'h404));
        check("b2b_count", 64'(fifo_count), 64'(0));

        // Reset mid-transaction; a late response must be ignored.
        tick(); rst = 1'b1; imem_req_ready = 1'b0; #1;
        check("midrst_req_valid", 64'(imem_req_valid), 64'(0));
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", 64'(perf_fetched), 64'(8));
        check("perf_flushes", 64'(perf_flushes), 64'(5));
`endif
        tick(); rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = word(9); #1;
        check("postrst_req_valid", 64'(imem_req_valid), 64'(1));
        check("postrst_req_addr", 64'(imem_req_addr), 64'(32'h0));
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched_rst", 64'(perf_fetched), 64'(0));
        check("perf_flushes_rst", 64'(perf_flushes), 64'(0));
`endif
        tick(); imem_rsp_valid = 1'b0; #1;
        check("postrst_count", 64'(fifo_count), 64'(0));
        check("postrst_dec_valid", 64'(dec_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, instruction address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, fetch queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-005 SHALL have ports:
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  imem_req_valid  out  1  fetch request valid.
  imem_req_ready  in  1  memory accepts request.
  imem_req_addr  out  ADDR_WIDTH  fetch address.
  imem_rsp_valid  in  1  instruction word returned.
  imem_rsp_data  in  DATA_WIDTH  instruction word.
  redirect_valid  in  1  branch/jump redirect from backend.
  redirect_pc  in  ADDR_WIDTH  redirect target.
  dec_valid  out  1  queue head valid toward decode.
  dec_ready  in  1  decode accepts head.
  dec_instruction_addr  out  ADDR_WIDTH  head instruction address.
  dec_instruction  out  DATA_WIDTH  head instruction word.
  fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries.

Function
REQ-006 SHALL implement FSM states S_REQ, S_WAIT, S_DROP, with at most one outstanding memory request.
REQ-007 In S_REQ: imem_req_valid = (fifo_count < FIFO_DEPTH) and not redirect_valid; imem_req_addr = pc.
REQ-008 On imem_req_valid and imem_req_ready: latch req_pc = pc, pc <= pc + 4 modulo 2^ADDR_WIDTH, go to S_WAIT.
REQ-009 imem_req_addr SHALL stay stable while imem_req_valid is high and imem_req_ready is low.
REQ-010 In S_WAIT, on imem_rsp_valid: push {req_pc, imem_rsp_data}, go to S_REQ; the push always has space.
REQ-011 imem_rsp_valid SHALL be ignored in S_REQ.
REQ-012 dec_valid = (fifo_count != 0); dec_instruction_addr and dec_instruction SHALL come from the head entry; the head pops on dec_valid and dec_ready.
REQ-013 A pushed entry SHALL be visible on dec_valid in the cycle after imem_rsp_valid; there is no bypass.
REQ-014 Simultaneous push and pop SHALL leave fifo_count unchanged; queue pointers wrap modulo FIFO_DEPTH.
REQ-015 Redirect has highest priority. In the redirect cycle: flush the queue (fifo_count <= 0, any pop ignored), set pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}, and hold imem_req_valid at 0.
REQ-016 Redirect in S_WAIT without imem_rsp_valid -> S_DROP; redirect in S_WAIT with imem_rsp_valid -> response discarded, go to S_REQ.
REQ-017 In S_DROP, the next imem_rsp_valid SHALL be discarded, then go to S_REQ.
REQ-018 Redirect in S_DROP SHALL stay in S_DROP and update pc.
REQ-019 Redirect in S_REQ SHALL stay in S_REQ.
REQ-020 Back-to-back redirects: the last one wins.

Reset
REQ-021 On rst: pc = RESET_PC, state = S_REQ, queue empty, and all outputs 0 (imem_req_valid, dec_valid, fifo_count, data/address outputs).
REQ-022 rst mid-transaction SHALL abandon any outstanding request; a response arriving after reset, while in S_REQ, is ignored.

Configuration
REQ-023 Macro FETCH_PERF_CNT_EN defined: add outputs perf_fetched (32 bits, counts pushes) and perf_flushes (32 bits, counts redirect cycles). Both counters wrap, reset to 0, and update in the same cycle as the event.
REQ-024 Macro FETCH_PERF_CNT_EN undefined: these ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-025 The fetch FSM state enum and the fetch packet struct {instruction_addr, instruction} SHALL live in typedef_pkg; the PC increment constant 4 SHALL live in instruction_pkg.
REQ-026 The queue SHALL be a sub-module fetch_fifo (parameters WIDTH and DEPTH; push, pop, flush, count), instantiated once.

Verification
REQ-027 Reset, then imem_req_ready=1 with responses one cycle after each request -> addresses 0x0, 0x4, 0x8 issued; with dec_ready=1, decode sees (0x0, w0), (0x4, w1) in order.
REQ-028 dec_ready=0 with continuous memory -> exactly 4 entries queued, fifo_count=4, imem_req_valid=0; dec_ready=1 for one cycle -> count 3, then a new request to 0x10.
REQ-029 Redirect to 0x103 while in S_WAIT, stale response arriving 2 cycles later -> stale word not queued; next request addr 0x100; count 0 after redirect.
REQ-030 Redirect in the same cycle as imem_rsp_valid and a dec handshake -> response dropped, count 0, state S_REQ, next request to the redirect target.
REQ-031 pc = 0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
REQ-032 With FETCH_PERF_CNT_EN: 5 pushes and 2 redirects -> perf_fetched=5, perf_flushes=2; rst -> both 0.
